// File: rtl/fifo_read_stream_adapter_if.sv
// Handshake bundle between the synchronous FIFO read side, the read-stream
// adapter and the downstream valid/ready consumer. The master modport is the
// adapter's view; the slave modport is the environment's view (FIFO plus consumer).
interface fifo_read_stream_adapter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH) + 1
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_r_en;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CNT_WIDTH-1:0]  buf_count;

  modport master (
    input  fifo_empty, fifo_data_out, flush, m_ready,
    output fifo_r_en, m_valid, m_data, buf_count
  );

  modport slave (
    output fifo_empty, fifo_data_out, flush, m_ready,
    input  fifo_r_en, m_valid, m_data, buf_count
  );
endinterface

// File: rtl/fifo_read_stream_adapter.sv
// Read-side adapter for the synchronous FIFO. It issues reads while a holding
// slot is free (counting the word still in flight), captures the FIFO's
// registered data one cycle later into a small circular buffer, and presents
// the buffer head as a valid/ready stream.
// Optional feature: define FIFO_READ_ADAPTER_BEAT_CNT_EN to add a 16-bit
// beat_count output counting stream handshakes since the last reset or flush.
module fifo_read_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fifo_read_stream_adapter_if.master  bus
`ifdef FIFO_READ_ADAPTER_BEAT_CNT_EN
  ,
  output logic [15:0]                 beat_count
`endif
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam logic [CNT_WIDTH:0] CREDIT_MAX = (CNT_WIDTH + 1)'(BUF_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  occ;
  logic                  inflight;
  logic [CNT_WIDTH:0]    credit_used;
  logic                  capture;
  logic                  drain;
  logic [DATA_WIDTH-1:0] hold_mem [BUF_DEPTH];

  assign occ         = wr_ptr - rd_ptr;
  // A word already requested but not yet captured still owns a slot.
  assign credit_used = {1'b0, occ} + {{CNT_WIDTH{1'b0}}, inflight};

  // Read request depends only on registered state, fifo_empty and flush;
  // gating with rst_n keeps the FIFO untouched while held in reset.
  assign bus.fifo_r_en = rst_n & ~bus.fifo_empty & ~bus.flush & (credit_used < CREDIT_MAX);

  assign bus.m_valid   = (wr_ptr != rd_ptr);
  assign bus.m_data    = hold_mem[rd_ptr[IDX_W-1:0]];
  assign bus.buf_count = occ;

  assign capture = inflight & ~bus.flush;
  assign drain   = bus.m_valid & bus.m_ready & ~bus.flush;

  // Pointer and in-flight tracking; flush empties the buffer and cancels the pending read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.fifo_r_en;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (capture) wr_ptr <= wr_ptr + CNT_WIDTH'(1);
        if (drain)   rd_ptr <= rd_ptr + CNT_WIDTH'(1);
      end
    end
  end

  // Holding storage: the word returned by last cycle's read lands at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) hold_mem[i] <= '0;
    end else if (capture) begin
      hold_mem[wr_ptr[IDX_W-1:0]] <= bus.fifo_data_out;
    end
  end

`ifdef FIFO_READ_ADAPTER_BEAT_CNT_EN
  // Handshake counter; flush clears it even when a handshake coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (bus.flush) begin
      beat_count <= '0;
    end else if (bus.m_valid && bus.m_ready) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Self-checking bench for fifo_read_stream_adapter. A queue models the FIFO
// contents; a second queue holds every word taken from the FIFO and not yet
// delivered downstream, from which read credit, occupancy, valid and head
// data are predicted each cycle.
module tb_fifo_read_stream_adapter;
  localparam int DATA_WIDTH = 8;
  localparam int BUF_DEPTH  = 4;
  localparam int CNT_WIDTH  = $clog2(BUF_DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_read_stream_adapter_if #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) bus ();

`ifdef FIFO_READ_ADAPTER_BEAT_CNT_EN
  logic [15:0] beat_count;
`endif

  fifo_read_stream_adapter #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef FIFO_READ_ADAPTER_BEAT_CNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  fifo_q [$];   // words still inside the FIFO
  logic [7:0]  exp_q  [$];   // words read from the FIFO, not yet delivered
  logic [7:0]  out_q  [$];   // words delivered downstream
  logic        read_last = 1'b0;
  logic [15:0] beat_exp  = '0;
  logic        empty_gate = 1'b0;

  // Pre-edge samples taken away from the clock edge
  logic       s_ren = 1'b0, s_valid = 1'b0, s_ready = 1'b0, s_flush = 1'b0, s_empty = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // FIFO model and scoreboard advance on each edge using the pre-edge samples
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fifo_data_out <= '0;
      exp_q.delete();
      read_last <= 1'b0;
      beat_exp  <= '0;
    end else begin
      if (s_flush) begin
        exp_q.delete();
        beat_exp <= '0;
      end else if (s_valid && s_ready) begin
        if (exp_q.size() > 0) out_q.push_back(exp_q.pop_front());
        beat_exp <= beat_exp + 16'd1;
      end
      if (s_ren) begin
        if (fifo_q.size() == 0) begin
          chk("read_from_empty_fifo", 32'(1), 32'(0));
        end else begin
          logic [7:0] w;
          w = fifo_q.pop_front();
          bus.fifo_data_out <= w;
          exp_q.push_back(w);
        end
      end
      read_last <= s_ren;
    end
  end

  // One clock cycle: settle inputs, compare outputs with the model, sample, advance
  task automatic cycle();
    int exp_cnt;
    bus.fifo_empty = empty_gate || (fifo_q.size() == 0);
    #1;
    exp_cnt = exp_q.size() - int'(read_last);
    chk("fifo_r_en", 32'(bus.fifo_r_en),
        32'(rst_n && !bus.fifo_empty && !bus.flush && (exp_q.size() < BUF_DEPTH)));
    chk("buf_count", 32'(bus.buf_count), 32'(exp_cnt));
    chk("m_valid", 32'(bus.m_valid), 32'(exp_cnt > 0));
    chk("no_overflow", 32'(bus.buf_count <= CNT_WIDTH'(BUF_DEPTH)), 32'(1));
    if (!rst_n) chk("m_data_reset", 32'(bus.m_data), 32'(0));
    else if (exp_cnt > 0) chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
`ifdef FIFO_READ_ADAPTER_BEAT_CNT_EN
    chk("beat_count", 32'(beat_count), 32'(beat_exp));
`endif
    s_ren   = bus.fifo_r_en;
    s_valid = bus.m_valid;
    s_ready = bus.m_ready;
    s_flush = bus.flush;
    s_empty = bus.fifo_empty;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_complete", 32'(fifo_q.size() + exp_q.size()), 32'(0));
  endtask

  initial begin
    int first_ren, first_vld, vld_cycles, reads, viol, ok;
    bus.flush      = 1'b0;
    bus.m_ready    = 1'b0;
    bus.fifo_empty = 1'b0;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    @(negedge clk);

    // Reset held with data waiting in the FIFO
    repeat (3) cycle();
    chk("rst_fifo_r_en", 32'(s_ren), 32'(0));

    // Streaming with constant ready
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    first_ren = -1; first_vld = -1; vld_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) chk("ren_first_cycle_after_reset", 32'(s_ren), 32'(1));
      if (s_ren && first_ren < 0) first_ren = cyc;
      if (s_valid && first_vld < 0) first_vld = cyc;
      if (s_valid) vld_cycles++;
    end
    chk("stream_latency", 32'(first_vld - first_ren), 32'(2));
    chk("stream_valid_cycles", 32'(vld_cycles), 32'(3));
    chk("stream_count", 32'(out_q.size()), 32'(3));
    if (out_q.size() == 3) begin
      chk("stream_w0", 32'(out_q[0]), 32'h11);
      chk("stream_w1", 32'(out_q[1]), 32'h22);
      chk("stream_w2", 32'(out_q[2]), 32'h33);
    end

    // Back-pressure: credit stops reads at buffer depth
    out_q.delete();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i));
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_ren) reads++;
    end
    chk("bp_reads", 32'(reads), 32'(4));
    chk("bp_buf_count", 32'(bus.buf_count), 32'(4));
    chk("bp_m_data_held", 32'(bus.m_data), 32'h00);
    bus.m_ready = 1'b1;
    drain(60);
    chk("bp_out_count", 32'(out_q.size()), 32'(8));
    for (int i = 0; i < out_q.size() && i < 8; i++) chk("bp_order", 32'(out_q[i]), 32'(i));

    // Empty flag toggling every cycle
    out_q.delete();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h40 + i));
    viol = 0;
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) begin
      empty_gate = ~empty_gate;
      cycle();
      if (s_ren && s_empty) viol++;
    end
    empty_gate = 1'b0;
    chk("empty_ren_violations", 32'(viol), 32'(0));
    chk("empty_out_count", 32'(out_q.size()), 32'(6));
    for (int i = 0; i < out_q.size() && i < 6; i++) chk("empty_order", 32'(out_q[i]), 32'(8'h40 + i));

    // Flush with three buffered words and one in flight
    out_q.delete();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h80 + i));
    for (int i = 0; i < 20 && !(exp_q.size() == 4 && read_last); i++) cycle();
    chk("flush_setup_count", 32'(bus.buf_count), 32'(3));
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk("flush_m_valid", 32'(bus.m_valid), 32'(0));
    chk("flush_buf_count", 32'(bus.buf_count), 32'(0));
    bus.m_ready = 1'b1;
    drain(60);
    chk("flush_out_count", 32'(out_q.size()), 32'(4));
    for (int i = 0; i < out_q.size() && i < 4; i++) chk("flush_order", 32'(out_q[i]), 32'(8'h84 + i));

    // Random ready with pointer wrap and a mid-stream reset
    out_q.delete();
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 400; i++) begin
      if (i > 15 && fifo_q.size() == 0 && exp_q.size() == 0) break;
      bus.m_ready = 1'($urandom_range(0, 1));
      empty_gate  = ($urandom_range(0, 3) == 0);
      if (i == 15) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 32'(0));
        chk("midrst_buf_count", 32'(bus.buf_count), 32'(0));
        chk("midrst_fifo_r_en", 32'(bus.fifo_r_en), 32'(0));
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    empty_gate = 1'b0;
    chk("rand_drained", 32'(fifo_q.size() + exp_q.size()), 32'(0));
    ok = (out_q.size() > 0) ? 1 : 0;
    for (int i = 1; i < out_q.size(); i++) if (out_q[i] <= out_q[i-1]) ok = 0;
    chk("rand_order", 32'(ok), 32'(1));
    if (out_q.size() > 0) chk("rand_last_word", 32'(out_q[out_q.size()-1]), 32'hB3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_read_stream_adapter.md
Name: fifo_read_stream_adapter

Overview:
Downstream consumer stage for the synchronous FIFO. It drives the FIFO read enable from `fifo_empty` and its own credit state, and captures the FIFO's registered `data_out` one cycle after each read. Captured words go into a small internal holding buffer, which is presented as a valid/ready stream to the next stage. Flow control is credit-based, so the holding buffer can never overflow and words are never dropped or duplicated.

Parameters:
- DATA_WIDTH, 8: width of a FIFO word and of `m_data`.
- BUF_DEPTH, 4: holding-buffer entries. Power of two, minimum 2. At least 3 is required for one-word-per-cycle throughput.
- CNT_WIDTH, $clog2(BUF_DEPTH)+1: width of `buf_count`. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
- fifo_r_en  output  1  read request to the FIFO.
- flush  input  1  synchronous flush of the holding buffer and any in-flight read.
- m_valid  output  1  stream word available.
- m_ready  input  1  downstream accepts.
- m_data  output  DATA_WIDTH  head of the holding buffer.
- buf_count  output  CNT_WIDTH  current holding-buffer occupancy, 0..BUF_DEPTH.

Behaviour:
- **Reset:** while rst_n=0, asynchronously clear all state. `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `buf_count`=0, `inflight`=0, pointers=0, storage=0. Reset mid-transfer discards the buffer and any in-flight word with no partial output.
- **State:**
  - `inflight`: 1-bit register, set when a read was issued last cycle.
  - Holding buffer: circular buffer with `wr_ptr`/`rd_ptr` of $clog2(BUF_DEPTH)+1 bits. The MSB is the wrap bit; empty means the pointers are equal; full means the MSBs differ and the low bits are equal.
- **Read issue:** `fifo_r_en` = !`fifo_empty` & !`flush` & (`buf_count` + `inflight` < BUF_DEPTH).
  - Combinational from registered state, `fifo_empty` and `flush` only.
  - No combinational path from `m_ready`.
- **In-flight tracking:** at each edge, `inflight` <= `fifo_r_en`.
- **Capture:** at an edge where `inflight`=1 and `flush`=0, write `fifo_data_out` to `buf[wr_ptr]` and increment `wr_ptr`.
- **Latency:** `fifo_r_en` sampled high at edge E gives the word in the buffer after E+1. `m_valid` is high from E+1 onward.
- **Output:** `m_valid` = buffer not empty. `m_data` = `buf[rd_ptr]`; `m_data` is don't-care while `m_valid`=0 except the post-reset value 0.
- **Drain:** at an edge where `m_valid`&`m_ready`=1 and `flush`=0, increment `rd_ptr`.
  - `m_valid`/`m_data` hold stable while `m_ready`=0.
- **Simultaneous capture and drain:** both pointers advance and `buf_count` is unchanged. This is also legal when the buffer is full, because the credit rule guarantees that capture only happens with a free slot counted.
- **Overflow check:** capture while full with no drain is impossible by construction. The bench asserts it never happens.
- **Flush:** at an edge with `flush`=1:
  - clear the pointers and `inflight`;
  - discard any word arriving that edge;
  - `fifo_r_en` is 0 that cycle;
  - `m_valid`=0 the next cycle;
  - normal operation resumes the cycle after `flush` deasserts.
- **Pointer wrap:** modular increment with the wrap MSB. `buf_count` = `wr_ptr` - `rd_ptr`, modulo 2^CNT_WIDTH.
- **Ordering:** words emerge in exactly FIFO read order.

Optional Feature:
- Macro: `FIFO_READ_ADAPTER_BEAT_CNT_EN`.
- Defined: adds output port `beat_count` (16 bits).
  - Increments on every `m_valid`&`m_ready` edge, wrapping 0xFFFF to 0x0000.
  - Cleared by reset and by `flush`.
  - A flush in the same cycle as a handshake takes priority.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- **Reset values:** assert rst_n=0 for 3 cycles with `fifo_empty`=0 -> `fifo_r_en`=0, `m_valid`=0, `m_data`=0x00, `buf_count`=0. After release, `fifo_r_en`=1 in the first cycle.
- **Streaming:** FIFO preloaded with 0x11,0x22,0x33, `m_ready`=1 constantly. Expect:
  - `m_data` 0x11,0x22,0x33 on three consecutive `m_valid` cycles;
  - first `m_valid` two edges after the first `fifo_r_en`;
  - no gaps.
- **Back-pressure:** FIFO holds 8 words 0x00..0x07, `m_ready`=0 -> `fifo_r_en` stops after exactly 4 reads, `buf_count`=4, `m_data`=0x00 held stable. Raising `m_ready` drains 0x00..0x07 in order with no loss or duplicate.
- **Empty boundary:** `fifo_empty` toggles 1/0 every cycle during transfer -> `fifo_r_en` never asserts while `fifo_empty`=1, and the output sequence is intact.
- **Flush:** `flush` for 1 cycle while `buf_count`=3 and `inflight`=1 -> next cycle `m_valid`=0 and `buf_count`=0. The in-flight word never appears, and subsequent words resume in order.
- **Wrap, reset mid-operation and beat count:** 20 words with random `m_ready`:
  - pointers wrap multiple times with order preserved;
  - rst_n pulsed low mid-stream clears the outputs immediately;
  - with `FIFO_READ_ADAPTER_BEAT_CNT_EN` defined, `beat_count` equals the handshakes since the last reset or flush.
